perip_laser_pwm: RTL and testbench

- Memory-mapped output peripheral on the femtorv bus that drives the 4 laser-diode emitters of the laser bass.
- It is the write/drive counterpart of the laser receiver peripheral: the CPU writes brightness, enable mask and prescaler, and the block generates glitch-free per-emitter PWM.
- Sits in the peripheral address decoder next to the laser receiver; its outputs go straight to the emitter driver pins.

---
 rtl/laser_pkg.sv | 22 ++
 rtl/pwm_channel.sv | 28 ++
 rtl/perip_laser_pwm.sv | 169 ++++++++++++++++
 tb/tb_perip_laser_pwm.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/laser_pkg.sv
// Shared register map and bit-field positions for the laser receiver and laser PWM peripherals.
package laser_pkg;

    localparam logic [4:0] REG_CTRL     = 5'h00;
    localparam logic [4:0] REG_GETLASER = 5'h02;
    localparam logic [4:0] REG_DUTY     = 5'h04;
    localparam logic [4:0] REG_PRESC    = 5'h08;
    localparam logic [4:0] REG_STATUS   = 5'h0C;

    localparam int unsigned BUS_W = 32;
    // One byte lane of DUTY per emitter
    localparam int unsigned LANE_W = 8;

    localparam int unsigned CTRL_EN_BIT   = 0;
    localparam int unsigned CTRL_MASK_LSB = 4;
    localparam int unsigned CTRL_MASK_W   = 4;

    localparam int unsigned STAT_PEND_BIT = 0;
    localparam int unsigned STAT_CAR_BIT  = 1;
    localparam int unsigned STAT_CNT_LSB  = 8;

endpackage

// File: rtl/pwm_channel.sv
// One emitter: shadow duty register reloaded at period end, compare against the shared counter, output flop.
module pwm_channel #(
    parameter int unsigned DUTY_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DUTY_W-1:0] i_duty,
    input  logic [DUTY_W-1:0] i_cnt,
    input  logic              i_en,
    output logic              o_out
);

    logic [DUTY_W-1:0] r_shadow;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shadow <= '0;
            o_out    <= 1'b0;
        end else begin
            if (i_load) begin
                r_shadow <= i_duty;
            end
            o_out <= i_en && (i_cnt < r_shadow);
        end
    end

endmodule

// File: rtl/perip_laser_pwm.sv
// Laser emitter PWM peripheral: bus registers, prescaler, shared PWM counter and per-emitter channels.
// Optional carrier gating is built when LASER_PWM_CARRIER_EN is defined.
module perip_laser_pwm #(
    parameter int unsigned NUM_LASERS  = 4,
    parameter int unsigned DUTY_W      = 8,
    parameter int unsigned PRESC_W     = 16,
    parameter int unsigned CARRIER_DIV = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           d_in,
    input  logic                  cs,
    input  logic [31:0]           addr,
    input  logic                  rd,
    input  logic                  wr,
    output logic [31:0]           d_out,
    output logic [NUM_LASERS-1:0] laser_out,
    output logic                  carrier
);

    import laser_pkg::*;

    logic                         r_enable;
    logic [NUM_LASERS-1:0]        r_mask;
    logic [NUM_LASERS*DUTY_W-1:0] r_duty;
    logic [PRESC_W-1:0]           r_presc;
    logic [PRESC_W-1:0]           r_presc_cnt;
    logic [DUTY_W-1:0]            r_pwm_cnt;
    logic                         r_pending;

    logic [4:0]                   w_off;
    logic                         w_wr;
    logic                         w_rd;
    logic                         w_duty_wr;
    logic                         w_tick;
    logic                         w_period_end;
    logic                         w_gate;
    logic                         w_carrier;
    logic [NUM_LASERS*DUTY_W-1:0] w_duty_wdata;
    logic [BUS_W-1:0]             w_duty_rdata;
    logic [BUS_W-1:0]             w_rdata;
    logic                         w_unused;

    assign w_off        = addr[4:0];
    assign w_wr         = cs && wr;
    assign w_rd         = cs && rd;
    assign w_duty_wr    = w_wr && (w_off == REG_DUTY);
    assign w_tick       = (r_presc_cnt == r_presc);
    assign w_period_end = w_tick && (r_pwm_cnt == '1);

    // Byte lane i of the bus word maps to emitter i
    for (genvar g = 0; g < NUM_LASERS; g++) begin : g_lane
        assign w_duty_wdata[g*DUTY_W +: DUTY_W] = d_in[g*LANE_W +: DUTY_W];
        assign w_duty_rdata[g*LANE_W +: LANE_W] = LANE_W'(r_duty[g*DUTY_W +: DUTY_W]);
    end
    if (NUM_LASERS < 4) begin : g_duty_pad
        assign w_duty_rdata[BUS_W-1:NUM_LASERS*LANE_W] = '0;
    end

    // Bus-visible registers and the counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_enable    <= 1'b0;
            r_mask      <= '0;
            r_duty      <= '0;
            r_presc     <= '0;
            r_presc_cnt <= '0;
            r_pwm_cnt   <= '0;
            r_pending   <= 1'b0;
        end else begin
            if (w_wr && (w_off == REG_CTRL)) begin
                r_enable <= d_in[CTRL_EN_BIT];
                r_mask   <= d_in[CTRL_MASK_LSB +: NUM_LASERS];
            end
            if (w_duty_wr) begin
                r_duty <= w_duty_wdata;
            end
            if (w_wr && (w_off == REG_PRESC)) begin
                r_presc     <= d_in[PRESC_W-1:0];
                r_presc_cnt <= '0;
            end else if (w_tick) begin
                r_presc_cnt <= '0;
            end else begin
                r_presc_cnt <= r_presc_cnt + PRESC_W'(1);
            end
            if (w_tick) begin
                r_pwm_cnt <= r_pwm_cnt + DUTY_W'(1);
            end
            // A DUTY write colliding with period end stays pending for the next period
            if (w_duty_wr) begin
                r_pending <= 1'b1;
            end else if (w_period_end) begin
                r_pending <= 1'b0;
            end
        end
    end

    // Read-data mux; values are pre-write when rd and wr coincide
    always_comb begin
        w_rdata = '0;
        case (w_off)
            REG_CTRL: begin
                w_rdata[CTRL_EN_BIT]                 = r_enable;
                w_rdata[CTRL_MASK_LSB +: NUM_LASERS] = r_mask;
            end
            REG_DUTY:   w_rdata = w_duty_rdata;
            REG_PRESC:  w_rdata[PRESC_W-1:0] = r_presc;
            REG_STATUS: begin
                w_rdata[STAT_PEND_BIT]          = r_pending;
                w_rdata[STAT_CAR_BIT]           = w_carrier;
                w_rdata[STAT_CNT_LSB +: DUTY_W] = r_pwm_cnt;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_out <= '0;
        end else if (w_rd) begin
            d_out <= w_rdata;
        end
    end

`ifdef LASER_PWM_CARRIER_EN
    localparam int unsigned CAR_W = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;

    logic [CAR_W-1:0] r_car_cnt;
    logic             r_carrier;

    // Square-wave carrier, half-period of CARRIER_DIV clocks
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_car_cnt <= '0;
            r_carrier <= 1'b0;
        end else if (r_car_cnt == CAR_W'(CARRIER_DIV - 1)) begin
            r_car_cnt <= '0;
            r_carrier <= ~r_carrier;
        end else begin
            r_car_cnt <= r_car_cnt + CAR_W'(1);
        end
    end

    assign w_carrier = r_carrier;
    assign w_gate    = r_carrier;
    assign w_unused  = ^addr[31:5];
`else
    assign w_carrier = 1'b0;
    assign w_gate    = 1'b1;
    assign w_unused  = ^{addr[31:5], 32'(CARRIER_DIV)};
`endif

    assign carrier = w_carrier;

    for (genvar g = 0; g < NUM_LASERS; g++) begin : g_ch
        pwm_channel #(
            .DUTY_W (DUTY_W)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .i_load (w_period_end),
            .i_duty (r_duty[g*DUTY_W +: DUTY_W]),
            .i_cnt  (r_pwm_cnt),
            .i_en   (r_enable && r_mask[g] && w_gate),
            .o_out  (laser_out[g])
        );
    end

endmodule

// File: tb/tb_perip_laser_pwm.sv
// Bench for perip_laser_pwm: cycle reference model plus directed duty-count checks and randomized rounds.
module tb_perip_laser_pwm;

    localparam int CDIV = 10;
    localparam logic [4:0] A_CTRL   = 5'h00;
    localparam logic [4:0] A_DUTY   = 5'h04;
    localparam logic [4:0] A_PRESC  = 5'h08;
    localparam logic [4:0] A_STATUS = 5'h0C;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] d_in;
    logic        cs;
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] d_out;
    logic [3:0]  laser_out;
    logic        carrier;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    perip_laser_pwm #(
        .NUM_LASERS  (4),
        .DUTY_W      (8),
        .PRESC_W     (16),
        .CARRIER_DIV (CDIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .d_in      (d_in),
        .cs        (cs),
        .addr      (addr),
        .rd        (rd),
        .wr        (wr),
        .d_out     (d_out),
        .laser_out (laser_out),
        .carrier   (carrier)
    );

    // Reference model state, plain integers
    bit        m_en;
    bit [3:0]  m_mask;
    int        m_duty [4];
    int        m_shadow [4];
    int        m_presc, m_pc, m_pwm, m_ccnt;
    bit        m_pend, m_car;
    bit [3:0]  m_out;
    bit [31:0] m_dout;
    bit        m_tick, m_end;
    bit [3:0]  m_nout;
    int        hi [4];
    int        m_hi [4];

    task automatic m_reset();
        m_en = 0; m_mask = 0; m_presc = 0; m_pc = 0; m_pwm = 0; m_ccnt = 0;
        m_pend = 0; m_car = 0; m_out = 0; m_dout = 0;
        for (int i = 0; i < 4; i++) begin
            m_duty[i] = 0;
            m_shadow[i] = 0;
        end
    endtask

    function automatic bit [31:0] m_read(input bit [4:0] off);
        case (off)
            A_CTRL:   return {24'd0, m_mask, 3'd0, m_en};
            A_DUTY:   return {8'(m_duty[3]), 8'(m_duty[2]), 8'(m_duty[1]), 8'(m_duty[0])};
            A_PRESC:  return 32'(m_presc);
            A_STATUS: return 32'(m_pwm * 256 + (m_car ? 2 : 0) + (m_pend ? 1 : 0));
            default:  return 32'd0;
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_reset();
        end else begin
            m_tick = (m_pc == m_presc);
            m_end  = m_tick && (m_pwm == 255);
            for (int i = 0; i < 4; i++) begin
                m_nout[i] = m_en && m_mask[i] && (m_pwm < m_shadow[i]);
`ifdef LASER_PWM_CARRIER_EN
                m_nout[i] = m_nout[i] && m_car;
`endif
            end
            if (cs && rd) m_dout = m_read(addr[4:0]);
            if (m_end) for (int i = 0; i < 4; i++) m_shadow[i] = m_duty[i];
            if (cs && wr && addr[4:0] == A_DUTY) m_pend = 1;
            else if (m_end) m_pend = 0;
            if (m_tick) m_pwm = (m_pwm + 1) % 256;
            m_pc = m_tick ? 0 : m_pc + 1;
            if (cs && wr) begin
                case (addr[4:0])
                    A_CTRL:  begin m_en = d_in[0]; m_mask = d_in[7:4]; end
                    A_DUTY:  for (int i = 0; i < 4; i++) m_duty[i] = int'(d_in[8*i +: 8]);
                    A_PRESC: begin m_presc = int'(d_in[15:0]); m_pc = 0; end
                    default: ;
                endcase
            end
`ifdef LASER_PWM_CARRIER_EN
            if (m_ccnt == CDIV - 1) begin
                m_ccnt = 0;
                m_car = !m_car;
            end else begin
                m_ccnt++;
            end
`endif
            m_out = m_nout;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check("laser_out", 32'(laser_out), 32'(m_out));
        check("d_out", d_out, m_dout);
        check("carrier", 32'(carrier), 32'(m_car));
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic set_addr(input logic [4:0] off);
        logic [31:0] r;
        r = $urandom;
        addr = {r[31:5], off};
    endtask

    task automatic bus_write(input logic [4:0] off, input logic [31:0] data);
        cs = 1; wr = 1; rd = 0; set_addr(off); d_in = data;
        cycle();
        cs = 0; wr = 0;
    endtask

    task automatic bus_read(input logic [4:0] off, output logic [31:0] data);
        cs = 1; rd = 1; wr = 0; set_addr(off);
        cycle();
        data = d_out;
        cs = 0; rd = 0;
    endtask

    task automatic wait_settle(input int budget);
        int n = 0;
        while (m_pend && n < budget) begin cycle(); n++; end
        check("settle_timeout", 32'(n < budget), 32'd1);
        run(2);
    endtask

    // Stops at the negedge before the edge where the counter is at target and ticks
    task automatic wait_pwm(input int target, input int budget);
        int n = 0;
        while (!(m_pwm == target && m_pc == m_presc) && n < budget) begin cycle(); n++; end
        check("pwm_timeout", 32'(n < budget), 32'd1);
    endtask

    task automatic wait_lit(input int budget);
        int n = 0;
        while (m_out != 4'hF && n < budget) begin cycle(); n++; end
        check("lit_timeout", 32'(n < budget), 32'd1);
    endtask

    task automatic count_high(input int n);
        for (int i = 0; i < 4; i++) begin hi[i] = 0; m_hi[i] = 0; end
        repeat (n) begin
            cycle();
            for (int i = 0; i < 4; i++) begin
                hi[i] += int'(laser_out[i]);
                m_hi[i] += int'(m_out[i]);
            end
        end
    endtask

    // Over one full period each emitter is high duty*(presc+1) clocks, unless masked
    task automatic check_counts(input string tag, input logic [31:0] duty, input logic [3:0] lit, input int p);
        int e;
        for (int i = 0; i < 4; i++) begin
`ifdef LASER_PWM_CARRIER_EN
            e = m_hi[i];
`else
            e = lit[i] ? int'(duty[8*i +: 8]) * (p + 1) : 0;
`endif
            check($sformatf("%s_l%0d", tag, i), 32'(hi[i]), 32'(e));
        end
    endtask

    initial begin
        logic [31:0] rdat;
        logic [31:0] rduty, rduty2;
        logic [3:0]  rmask;
        logic        ren;
        int          rp, ccount;

        m_reset();
        rst = 0; cs = 0; rd = 0; wr = 0; addr = 0; d_in = 0;
        #1;
        check("rst_laser", 32'(laser_out), 32'd0);
        check("rst_dout", d_out, 32'd0);
        check("rst_carrier", 32'(carrier), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst = 1;
        run(3);

        // Basic PWM at full tick rate
        bus_write(A_PRESC, 32'd0);
        bus_write(A_DUTY, 32'h40FF0080);
        bus_write(A_CTRL, 32'h000000F1);
        wait_settle(600);
        count_high(256);
        check_counts("basic", 32'h40FF0080, 4'hF, 0);

        // Asynchronous reset while every emitter is lit
        bus_write(A_DUTY, 32'hFFFFFFFF);
        wait_settle(600);
        wait_lit(600);
        #2 rst = 0;
        #1;
        check("midrst_laser", 32'(laser_out), 32'd0);
        check("midrst_dout", d_out, 32'd0);
        check("midrst_carrier", 32'(carrier), 32'd0);
        @(negedge clk);
        cs = 1; rd = 1; set_addr(A_STATUS);
        #2 rst = 1;
        cycle();
        cs = 0; rd = 0;
        check("post_rst_status", d_out, 32'd0);
        bus_read(A_CTRL, rdat);
        check("post_rst_ctrl", rdat, 32'd0);
        bus_read(A_DUTY, rdat);
        check("post_rst_duty", rdat, 32'd0);

        // Shadows stay zero until a DUTY write reaches a period end
        bus_write(A_CTRL, 32'h000000F1);
        count_high(300);
        check("post_rst_dark", 32'(hi[0] + hi[1] + hi[2] + hi[3]), 32'd0);

        // Glitch-free update in mid-period
        bus_write(A_DUTY, 32'h10203040);
        wait_settle(600);
        wait_pwm(100, 600);
        bus_write(A_DUTY, 32'h80808080);
        bus_read(A_STATUS, rdat);
        check("glitch_pending", 32'(rdat[0]), 32'd1);
        wait_settle(600);
        bus_read(A_STATUS, rdat);
        check("glitch_cleared", 32'(rdat[0]), 32'd0);
        count_high(256);
        check_counts("glitch", 32'h80808080, 4'hF, 0);

        // DUTY write exactly at period end keeps the old duty one more period
        wait_pwm(255, 600);
        bus_write(A_DUTY, 32'h20202020);
        bus_read(A_STATUS, rdat);
        check("collide_pending", 32'(rdat[0]), 32'd1);
        run(100);
        bus_read(A_STATUS, rdat);
        check("collide_still", 32'(rdat[0]), 32'd1);
        wait_settle(600);
        count_high(256);
        check_counts("collide", 32'h20202020, 4'hF, 0);

        // Mask and prescaler
        bus_write(A_CTRL, 32'h00000051);
        bus_write(A_PRESC, 32'd3);
        bus_write(A_DUTY, 32'h80604020);
        wait_settle(2500);
        count_high(1024);
        check_counts("mask_presc", 32'h80604020, 4'h5, 3);
        bus_read(A_PRESC, rdat);
        check("presc_rb", rdat, 32'd3);

        // Disable drives everything low one edge after the write lands
        bus_write(A_PRESC, 32'd0);
        bus_write(A_DUTY, 32'hFFFFFFFF);
        bus_write(A_CTRL, 32'h000000F1);
        wait_settle(600);
        wait_lit(600);
        bus_write(A_CTRL, 32'h00000000);
        cycle();
        check("disable", 32'(laser_out), 32'd0);

        // Carrier activity over 100 clocks
        ccount = 0;
        repeat (100) begin
            cycle();
            ccount += int'(carrier);
        end
`ifdef LASER_PWM_CARRIER_EN
        check("carrier_duty", 32'(ccount), 32'd50);
`else
        check("carrier_idle", 32'(ccount), 32'd0);
`endif

        // Randomized rounds
        for (int r = 0; r < 6; r++) begin
            rduty  = $urandom;
            rduty2 = $urandom;
            rmask  = 4'($urandom);
            ren    = ($urandom_range(0, 3) != 0);
            rp     = $urandom_range(0, 2);
            bus_write(A_PRESC, 32'(rp));
            bus_write(A_DUTY, rduty);
            bus_write(A_CTRL, {24'd0, rmask, 3'd0, ren});
            repeat (8) begin
                bus_read(5'($urandom), rdat);
                run($urandom_range(0, 20));
            end
            cs = 1; rd = 1; wr = 1; set_addr(A_DUTY); d_in = rduty2;
            cycle();
            cs = 0; rd = 0; wr = 0;
            check("rdwr_prewrite", d_out, rduty);
            wait_settle(3000);
            count_high(256 * (rp + 1));
            check_counts($sformatf("rand%0d", r), rduty2, ren ? rmask : 4'h0, rp);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
